// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS 7:1 transmit link controller.
// Pure declarations: no latency, no flow control.
// State encoding matches the O_state numbering seen by software.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_TRAIN    = 2'd1,
        ST_WAIT_SOF = 2'd2,
        ST_ACTIVE   = 2'd3
    } state_t;

    localparam logic [6:0] CLK_PATTERN = 7'b1100011;
    localparam logic [6:0] PRBS_SEED   = 7'h7F;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } pix_t;

    localparam pix_t BLANK_PIX = '0;

    // lanes[n] is the 7-bit word for data lane n, bit 6 leaves the serializer first
    typedef logic [3:0][6:0] lanes_t;

    // PRBS7, x^7 + x^6 + 1, shifting towards the MSB
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/lvds_rgb_lane_map.sv
// RGB888 + HS/VS/DE to four 7-bit LVDS data lane words (VESA or JEIDA order).
// Latency: purely combinational.
// Backpressure: none, maps whatever is presented.
module lvds_rgb_lane_map
    import lvds_tx_pkg::*;
#(
    parameter int MAP_JEIDA = 0
) (
    input  pix_t   pix,
    output lanes_t lanes
);

    always_comb begin
        lanes = '0;
        if (MAP_JEIDA != 0) begin
            lanes[0] = {pix.g[2], pix.r[7:2]};
            lanes[1] = {pix.b[3:2], pix.g[7:3]};
            lanes[2] = {pix.de, pix.vs, pix.hs, pix.b[7:4]};
            lanes[3] = {1'b0, pix.b[1:0], pix.g[1:0], pix.r[1:0]};
        end else begin
            lanes[0] = {pix.g[0], pix.r[5:0]};
            lanes[1] = {pix.b[1:0], pix.g[5:1]};
            lanes[2] = {pix.de, pix.vs, pix.hs, pix.b[5:2]};
            lanes[3] = {1'b0, pix.b[7:6], pix.g[7:6], pix.r[7:6]};
        end
    end

endmodule

// File: rtl/lvds_tx_link_ctrl.sv
// LVDS 7:1 TX sequencer: serdes reset hold, training, SOF wait, pixel streaming.
// Latency: 1 cycle from accepted pixel beat to O_laneN; all outputs registered.
// Backpressure: O_pix_ready high only in WAIT_SOF/ACTIVE; optional LVDS_TX_PRBS_TRAIN_EN.
module lvds_tx_link_ctrl
    import lvds_tx_pkg::*;
#(
    parameter int RST_CYC   = 16,
    parameter int TRAIN_CYC = 1024,
    parameter int MAP_JEIDA = 0
) (
    input  logic        I_clk_1x,
    input  logic        I_rst_n,
    input  logic        I_enable,
    input  logic        I_pix_valid,
    input  logic [23:0] I_pix_data,
    input  logic        I_hs,
    input  logic        I_vs,
    input  logic        I_de,
    output logic        O_pix_ready,
    output logic        O_serdes_rst,
    output logic [6:0]  O_lane0,
    output logic [6:0]  O_lane1,
    output logic [6:0]  O_lane2,
    output logic [6:0]  O_lane3,
    output logic [6:0]  O_clk_lane,
    output logic [1:0]  O_state,
    output logic [15:0] O_underflow_cnt
);

    localparam int CNT_MAX = (RST_CYC > TRAIN_CYC) ? RST_CYC : TRAIN_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs_q, vs_q, hs_d, vs_d;
    logic             accept, sof;
    logic [15:0]      ufl_d;
    pix_t             map_pix;
    lanes_t           map_lanes, lanes_d;
    logic [6:0]       clk_lane_d, train_word;

    lvds_rgb_lane_map #(
        .MAP_JEIDA (MAP_JEIDA)
    ) u_map (
        .pix   (map_pix),
        .lanes (map_lanes)
    );

`ifdef LVDS_TX_PRBS_TRAIN_EN
    logic [6:0] lfsr_q;

    // First TRAIN word is always the seed, so re-entry restarts the sequence
    assign train_word = (state_q == ST_TRAIN) ? lfsr_q : PRBS_SEED;

    always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lfsr_q <= PRBS_SEED;
        end else if (state_d == ST_TRAIN) begin
            lfsr_q <= prbs7_step(train_word);
        end
    end
`else
    assign train_word = CLK_PATTERN;
`endif

    always_comb begin
        accept  = I_pix_valid && O_pix_ready;
        sof     = accept && I_vs && !vs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        map_pix = BLANK_PIX;
        ufl_d   = O_underflow_cnt;

        if (state_q == ST_ACTIVE && !I_pix_valid && O_underflow_cnt != 16'hFFFF) begin
            ufl_d = O_underflow_cnt + 16'd1;
        end

        if (!I_enable) begin
            state_d = ST_RST_HOLD;
            cnt_d   = '0;
            hs_d    = 1'b0;
            vs_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RST_HOLD: begin
                    hs_d = 1'b0;
                    vs_d = 1'b0;
                    if (cnt_q == RST_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_TRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_TRAIN: begin
                    if (cnt_q == TRAIN_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_SOF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_SOF: begin
                    if (accept) begin
                        hs_d = I_hs;
                        vs_d = I_vs;
                    end
                    if (sof) begin
                        state_d = ST_ACTIVE;
                        map_pix = '{r: I_pix_data[23:16], g: I_pix_data[15:8],
                                    b: I_pix_data[7:0], hs: I_hs, vs: I_vs, de: I_de};
                    end
                end
                default: begin
                    if (accept) begin
                        hs_d    = I_hs;
                        vs_d    = I_vs;
                        map_pix = '{r: I_pix_data[23:16], g: I_pix_data[15:8],
                                    b: I_pix_data[7:0], hs: I_hs, vs: I_vs, de: I_de};
                    end else begin
                        // underflow: blank pixel but keep sync levels stable
                        map_pix.hs = hs_q;
                        map_pix.vs = vs_q;
                    end
                end
            endcase
        end

        clk_lane_d = (state_d == ST_RST_HOLD) ? 7'h00 : CLK_PATTERN;
        case (state_d)
            ST_RST_HOLD: lanes_d = '0;
            ST_TRAIN:    lanes_d = {4{train_word}};
            default:     lanes_d = map_lanes;
        endcase
    end

    always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q         <= ST_RST_HOLD;
            cnt_q           <= '0;
            hs_q            <= 1'b0;
            vs_q            <= 1'b0;
            O_pix_ready     <= 1'b0;
            O_serdes_rst    <= 1'b1;
            O_lane0         <= 7'h00;
            O_lane1         <= 7'h00;
            O_lane2         <= 7'h00;
            O_lane3         <= 7'h00;
            O_clk_lane      <= 7'h00;
            O_underflow_cnt <= 16'h0000;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hs_q            <= hs_d;
            vs_q            <= vs_d;
            O_pix_ready     <= (state_d == ST_WAIT_SOF) || (state_d == ST_ACTIVE);
            O_serdes_rst    <= (state_d == ST_RST_HOLD);
            O_lane0         <= lanes_d[0];
            O_lane1         <= lanes_d[1];
            O_lane2         <= lanes_d[2];
            O_lane3         <= lanes_d[3];
            O_clk_lane      <= clk_lane_d;
            O_underflow_cnt <= ufl_d;
        end
    end

    assign O_state = state_q;

endmodule

// File: tb/tb_lvds_tx_link_ctrl.sv
// Directed bench for lvds_tx_link_ctrl: one VESA and one JEIDA instance on shared stimulus.
// Expected lane words are hand-derived from the bit maps.
module tb_lvds_tx_link_ctrl;

    localparam int         RST_CYC   = 4;
    localparam int         TRAIN_CYC = 8;
    localparam logic [6:0] PAT       = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        hs = 1'b0, vs = 1'b0, de = 1'b0;

    logic        rdy_v, srst_v, rdy_j, srst_j;
    logic [6:0]  l0_v, l1_v, l2_v, l3_v, ck_v;
    logic [6:0]  l0_j, l1_j, l2_j, l3_j, ck_j;
    logic [1:0]  st_v, st_j;
    logic [15:0] ufl_v, ufl_j;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lvds_tx_link_ctrl #(.RST_CYC(RST_CYC), .TRAIN_CYC(TRAIN_CYC), .MAP_JEIDA(0)) dut (
        .I_clk_1x(clk), .I_rst_n(rst_n), .I_enable(enable), .I_pix_valid(pix_valid),
        .I_pix_data(pix_data), .I_hs(hs), .I_vs(vs), .I_de(de),
        .O_pix_ready(rdy_v), .O_serdes_rst(srst_v),
        .O_lane0(l0_v), .O_lane1(l1_v), .O_lane2(l2_v), .O_lane3(l3_v),
        .O_clk_lane(ck_v), .O_state(st_v), .O_underflow_cnt(ufl_v)
    );

    lvds_tx_link_ctrl #(.RST_CYC(RST_CYC), .TRAIN_CYC(TRAIN_CYC), .MAP_JEIDA(1)) dut_j (
        .I_clk_1x(clk), .I_rst_n(rst_n), .I_enable(enable), .I_pix_valid(pix_valid),
        .I_pix_data(pix_data), .I_hs(hs), .I_vs(vs), .I_de(de),
        .O_pix_ready(rdy_j), .O_serdes_rst(srst_j),
        .O_lane0(l0_j), .O_lane1(l1_j), .O_lane2(l2_j), .O_lane3(l3_j),
        .O_clk_lane(ck_j), .O_state(st_j), .O_underflow_cnt(ufl_j)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_lanes_v(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        chk({tag, "_v_l0"}, 32'(l0_v), 32'(e0));
        chk({tag, "_v_l1"}, 32'(l1_v), 32'(e1));
        chk({tag, "_v_l2"}, 32'(l2_v), 32'(e2));
        chk({tag, "_v_l3"}, 32'(l3_v), 32'(e3));
    endtask

    task automatic chk_lanes_j(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        chk({tag, "_j_l0"}, 32'(l0_j), 32'(e0));
        chk({tag, "_j_l1"}, 32'(l1_j), 32'(e1));
        chk({tag, "_j_l2"}, 32'(l2_j), 32'(e2));
        chk({tag, "_j_l3"}, 32'(l3_j), 32'(e3));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic h, input logic vv, input logic d);
        pix_valid = v;
        pix_data  = {r, g, b};
        hs        = h;
        vs        = vv;
        de        = d;
    endtask

    // Walks RST_HOLD then n_train TRAIN cycles; a full train run must land in WAIT_SOF
    task automatic bringup(input int n_train);
        logic [6:0] w;
`ifdef LVDS_TX_PRBS_TRAIN_EN
        w = 7'h7F;
`else
        w = PAT;
`endif
        for (int i = 0; i < RST_CYC; i++) begin
            chk("rst_hold_state", 32'(st_v), 32'd0);
            chk("rst_hold_serdes_rst", 32'(srst_v), 32'd1);
            chk("rst_hold_clk_lane", 32'(ck_v), 32'h00);
            step();
        end
        for (int i = 0; i < n_train; i++) begin
            chk("train_state", 32'(st_v), 32'd1);
            chk("train_serdes_rst", 32'(srst_v), 32'd0);
            chk("train_ready", 32'(rdy_v), 32'd0);
            chk("train_clk_lane", 32'(ck_v), 32'(PAT));
            chk_lanes_v("train", w, w, w, w);
            chk("train_j_l2", 32'(l2_j), 32'(w));
`ifdef LVDS_TX_PRBS_TRAIN_EN
            w = {w[5:0], w[6] ^ w[5]};
`endif
            step();
        end
        if (n_train == TRAIN_CYC) begin
            chk("wait_sof_state", 32'(st_v), 32'd2);
            chk("wait_sof_ready", 32'(rdy_v), 32'd1);
            chk("wait_sof_clk_lane", 32'(ck_v), 32'(PAT));
        end
    endtask

    initial begin
        enable = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("reset_state", 32'(st_v), 32'd0);
        chk("reset_serdes_rst", 32'(srst_v), 32'd1);
        chk("reset_ready", 32'(rdy_v), 32'd0);
        chk("reset_clk_lane", 32'(ck_v), 32'h00);
        chk("reset_ufl", 32'(ufl_v), 32'd0);
        chk("reset_j_state", 32'(st_j), 32'd0);
        chk("reset_j_serdes_rst", 32'(srst_j), 32'd1);
        chk("reset_j_ready", 32'(rdy_j), 32'd0);
        chk("reset_j_clk_lane", 32'(ck_j), 32'h00);
        chk("reset_j_ufl", 32'(ufl_j), 32'd0);
        chk_lanes_v("reset", 7'h00, 7'h00, 7'h00, 7'h00);
        rst_n = 1'b1;

        bringup(TRAIN_CYC);

        // Pre-SOF beats with VS low are swallowed, lanes stay blank
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hAA, 8'h55, 8'hC3, 1'b1, 1'b0, 1'b1);
            step();
            chk("pre_sof_state", 32'(st_v), 32'd2);
            chk("pre_sof_ready", 32'(rdy_v), 32'd1);
            chk_lanes_v("pre_sof", 7'h00, 7'h00, 7'h00, 7'h00);
            chk_lanes_j("pre_sof", 7'h00, 7'h00, 7'h00, 7'h00);
        end

        // SOF beat: R=FF, VS=1, DE=0
        drive(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        chk("sof_state", 32'(st_v), 32'd3);
        chk("sof_j_state", 32'(st_j), 32'd3);
        chk_lanes_v("sof", 7'b0111111, 7'h00, 7'b0100000, 7'b0000011);
        chk_lanes_j("sof", 7'b0111111, 7'h00, 7'b0100000, 7'b0000011);

        // R=03, DE=1, VS=1
        drive(1'b1, 8'h03, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        chk_lanes_v("px_r03", 7'b0000011, 7'h00, 7'b1100000, 7'h00);
        chk_lanes_j("px_r03", 7'h00, 7'h00, 7'b1100000, 7'b0000011);

        // B=A5, HS=VS=DE=1
        drive(1'b1, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1);
        step();
        chk_lanes_v("px_ba5", 7'h00, 7'h20, 7'h79, 7'h20);
        chk_lanes_j("px_ba5", 7'h00, 7'h20, 7'h7A, 7'h10);

        // R=81, G=3C, HS=1, VS=0, DE=1
        drive(1'b1, 8'h81, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1);
        step();
        chk_lanes_v("px_r81g3c", 7'h01, 7'h1E, 7'h50, 7'h02);
        chk_lanes_j("px_r81g3c", 7'h60, 7'h07, 7'h50, 7'h01);
        chk("active_ufl_zero", 32'(ufl_v), 32'd0);

        // Underflow: blank, HS=1/VS=0 held from the last beat
        drive(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("ufl_count", 32'(ufl_v), 32'(i));
            chk("ufl_state", 32'(st_v), 32'd3);
            chk_lanes_v("ufl_blank", 7'h00, 7'h00, 7'h10, 7'h00);
            chk("ufl_j_l2", 32'(l2_j), 32'h10);
        end

        for (int i = 0; i < 65535; i++) step();
        chk("ufl_saturated", 32'(ufl_v), 32'hFFFF);
        step();
        chk("ufl_stays_saturated", 32'(ufl_v), 32'hFFFF);

        // Enable dropped with a valid beat in flight
        drive(1'b1, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b1);
        enable = 1'b0;
        step();
        chk("disable_state", 32'(st_v), 32'd0);
        chk("disable_serdes_rst", 32'(srst_v), 32'd1);
        chk("disable_ready", 32'(rdy_v), 32'd0);
        chk("disable_clk_lane", 32'(ck_v), 32'h00);
        chk("disable_ufl_kept", 32'(ufl_v), 32'hFFFF);
        chk_lanes_v("disable", 7'h00, 7'h00, 7'h00, 7'h00);

        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        bringup(3);

        // Async reset mid-TRAIN takes effect without a clock edge
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(st_v), 32'd0);
        chk("arst_serdes_rst", 32'(srst_v), 32'd1);
        chk("arst_ready", 32'(rdy_v), 32'd0);
        chk("arst_clk_lane", 32'(ck_v), 32'h00);
        chk("arst_ufl", 32'(ufl_v), 32'd0);
        chk_lanes_v("arst", 7'h00, 7'h00, 7'h00, 7'h00);
        step();
        rst_n = 1'b1;

        bringup(TRAIN_CYC);
        drive(1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        chk("resof_state", 32'(st_v), 32'd3);
        chk_lanes_v("resof", 7'b1000000, 7'h00, 7'b1100000, 7'h00);
        chk_lanes_j("resof", 7'h00, 7'h00, 7'b1100000, 7'b0000100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
